// File: rtl/aes_pkg.sv
// Shared definitions for the encryption feeder: block geometry, default
// encryption latency and the feeder state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W         = 128;
  localparam int AES_WORD_W          = 32;
  localparam int WORDS_PER_BLOCK     = 4;
  localparam int ENC_LATENCY_DEFAULT = 31;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ENCRYPT = 2'd1,
    ST_OUTPUT  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/encryption_feeder.sv
// Encryption feeder: packs four 32-bit plaintext words into a 128-bit block,
// holds key/block stable to an external encryption block for ENC_LATENCY
// cycles, captures the ciphertext and offers it to a consumer.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. word_ready is a pure function of state and cipher_valid is a
// register, so neither ready nor valid ever depends combinationally on its
// partner signal.
module encryption_feeder
  import aes_pkg::*;
#(
  parameter int ENC_LATENCY = ENC_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [AES_BLOCK_W-1:0] key_in,
  input  logic                   key_load,
  input  logic [AES_WORD_W-1:0]  word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   encryptEnable,
  output logic [AES_BLOCK_W-1:0] key,
  output logic [AES_BLOCK_W-1:0] inputData,
  input  logic [AES_BLOCK_W-1:0] outputData,
  output logic [AES_BLOCK_W-1:0] cipher_out,
  output logic                   cipher_valid,
  input  logic                   cipher_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  // Value of the latency counter during the last ENCRYPT cycle.
  localparam logic [7:0] LAT_LAST = 8'(ENC_LATENCY - 1);
  localparam logic [1:0] WORD_LAST = 2'(WORDS_PER_BLOCK - 1);

  feeder_state_t          r_state;
  feeder_state_t          w_next_state;
  logic [1:0]             r_word_cnt;
  logic [7:0]             r_lat_cnt;
  logic [AES_BLOCK_W-1:0] r_key;
  logic [AES_BLOCK_W-1:0] r_input_data;
  logic [AES_BLOCK_W-1:0] r_cipher_out;
  logic                   r_encrypt_en;
  logic                   r_cipher_valid;

  logic w_word_acc;
  logic w_last_word;
  logic w_lat_done;
  logic w_key_acc;
  logic w_out_done;

  assign w_word_acc  = word_valid && (r_state == ST_COLLECT);
  assign w_last_word = w_word_acc && (r_word_cnt == WORD_LAST);
  assign w_lat_done  = (r_state == ST_ENCRYPT) && (r_lat_cnt == LAT_LAST);
  // Key is frozen while the encryption block is working on it.
  assign w_key_acc   = key_load && (r_state != ST_ENCRYPT);
  assign w_out_done  = r_cipher_valid && cipher_ready;

  assign word_ready    = (r_state == ST_COLLECT);
  assign busy          = (r_state != ST_COLLECT);
  assign encryptEnable = r_encrypt_en;
  assign key           = r_key;
  assign inputData     = r_input_data;
  assign cipher_out    = r_cipher_out;
  assign cipher_valid  = r_cipher_valid;
  assign dbg_state     = r_state;

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COLLECT: if (w_last_word) w_next_state = ST_ENCRYPT;
      ST_ENCRYPT: if (w_lat_done)  w_next_state = ST_OUTPUT;
      ST_OUTPUT:  if (w_out_done)  w_next_state = ST_COLLECT;
      default:                     w_next_state = ST_COLLECT;
    endcase
  end

  // State register; enable/valid are registered from the next state so they
  // line up exactly with the ENCRYPT and OUTPUT states.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state        <= ST_COLLECT;
      r_encrypt_en   <= 1'b0;
      r_cipher_valid <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_encrypt_en   <= (w_next_state == ST_ENCRYPT);
      r_cipher_valid <= (w_next_state == ST_OUTPUT);
    end
  end

  // Word assembly: first word lands in the MSBs; counter wraps after four.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_word_cnt   <= 2'd0;
      r_input_data <= '0;
    end else if (w_word_acc) begin
      r_word_cnt <= r_word_cnt + 2'd1;
      case (r_word_cnt)
        2'd0:    r_input_data[127:96] <= word_in;
        2'd1:    r_input_data[95:64]  <= word_in;
        2'd2:    r_input_data[63:32]  <= word_in;
        default: r_input_data[31:0]   <= word_in;
      endcase
    end
  end

  // Latency counter: counts ENCRYPT cycles, idles at zero elsewhere.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_lat_cnt <= 8'd0;
    end else if (r_state == ST_ENCRYPT && !w_lat_done) begin
      r_lat_cnt <= r_lat_cnt + 8'd1;
    end else begin
      r_lat_cnt <= 8'd0;
    end
  end

  // Key register and ciphertext capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_key        <= '0;
      r_cipher_out <= '0;
    end else begin
      if (w_key_acc)  r_key        <= key_in;
      if (w_lat_done) r_cipher_out <= outputData;
    end
  end

endmodule

// File: tb/tb_encryption_feeder.sv
// Bench for encryption_feeder. A stand-in encryption block returns
// cipher_fn(key, inputData) only in the cycle the feeder must sample it, so
// any latency error corrupts the captured ciphertext. A cycle-level model
// predicts every output; an expected queue tracks completed ciphertexts.
module tb_encryption_feeder;

  localparam int L = 31;

  logic         clk;
  logic         n_rst;
  logic [127:0] key_in;
  logic         key_load;
  logic [31:0]  word_in;
  logic         word_valid;
  logic         word_ready;
  logic         encryptEnable;
  logic [127:0] key;
  logic [127:0] inputData;
  logic [127:0] outputData;
  logic [127:0] cipher_out;
  logic         cipher_valid;
  logic         cipher_ready;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_hs   = 0;

  logic [127:0] exp_q[$];

  // Model state: key, block, words collected, ENCRYPT cycles left, output.
  logic [127:0] m_key;
  logic [127:0] m_data;
  logic [127:0] m_cipher;
  int           m_words;
  int           m_enc_left;
  bit           m_out_valid;

  encryption_feeder #(.ENC_LATENCY(L)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .encryptEnable(encryptEnable),
    .key          (key),
    .inputData    (inputData),
    .outputData   (outputData),
    .cipher_out   (cipher_out),
    .cipher_valid (cipher_valid),
    .cipher_ready (cipher_ready),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stand-in encryption block ----------------
  function automatic logic [127:0] cipher_fn(input logic [127:0] k, input logic [127:0] d);
    return k ^ {d[95:0], d[127:96]};
  endfunction

  logic [7:0] en_cnt = 8'd0;
  always @(posedge clk) en_cnt <= encryptEnable ? en_cnt + 8'd1 : 8'd0;
  assign outputData = (en_cnt == 8'(L - 1)) ? cipher_fn(key, inputData)
                                            : ~cipher_fn(key, inputData);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key       = '0;
    m_data      = '0;
    m_cipher    = '0;
    m_words     = 0;
    m_enc_left  = 0;
    m_out_valid = 0;
    exp_q.delete();
  endtask

  // Advance the model across the next posedge using the inputs now applied.
  task automatic model_step();
    bit accept;
    bit kl;
    accept = (m_enc_left == 0) && !m_out_valid && word_valid;
    kl     = key_load && (m_enc_left == 0);
    if (m_enc_left > 0) begin
      m_enc_left--;
      if (m_enc_left == 0) begin
        m_cipher    = cipher_fn(m_key, m_data);
        m_out_valid = 1;
        exp_q.push_back(m_cipher);
      end
    end else if (m_out_valid) begin
      if (cipher_ready) m_out_valid = 0;
    end else if (accept) begin
      m_data[127 - 32*m_words -: 32] = word_in;
      m_words++;
      if (m_words == 4) begin
        m_words    = 0;
        m_enc_left = L;
      end
    end
    if (kl) m_key = key_in;
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    logic [127:0] e;
    bit pred_ready;
    forever begin
      @(negedge clk);
      if (!n_rst) model_reset();
      pred_ready = (m_enc_left == 0) && !m_out_valid;
      check("word_ready",    word_ready,    pred_ready);
      check("busy",          busy,          !pred_ready);
      check("encryptEnable", encryptEnable, m_enc_left > 0);
      check("cipher_valid",  cipher_valid,  m_out_valid);
      check("cipher_out",    cipher_out,    m_cipher);
      check("key",           key,           m_key);
      check("inputData",     inputData,     m_data);
      if (n_rst && cipher_valid && cipher_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("unexpected_cipher", cipher_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_cipher", cipher_out, e);
        end
      end
      if (n_rst) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    word_valid = 1'b1;
    word_in    = w;
    while (!word_ready && t < 100) begin
      tick();
      t++;
    end
    check("send_word_ready", word_ready, 1'b1);
    tick();
    word_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] d, input int gap,
                            input bit key_first, input bit key_with_last);
    if (key_first) load_key(k);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && key_with_last) begin
        key_load = 1'b1;
        key_in   = k;
      end
      send_word(d[127 - 32*i -: 32]);
      key_load = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
  endtask

  task automatic wait_cipher(input int hold, output int lat);
    lat = 0;
    while (!cipher_valid && lat < 300) begin
      tick();
      lat++;
    end
    check("cipher_valid_seen", cipher_valid, 1'b1);
    repeat (hold) begin
      check("bp_word_ready", word_ready, 1'b0);
      tick();
    end
    cipher_ready = 1'b1;
    tick();
    cipher_ready = 1'b0;
    check("released_word_ready", word_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [127:0] K1 = 128'h5E74E7BA66B0C7CC1B7697B3F9F51527;
  localparam logic [127:0] D1 = 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D;
  localparam logic [127:0] C1 = 128'h91D441716F4B9AC9B39ACFDE847FF5D0;
  localparam logic [127:0] K2 = 128'h33DE20E331BA5A525AB7C2495A767B5A;
  localparam logic [127:0] D2 = 128'hE6FEBF30133874EBCB49226CD36D0D4F;
  localparam logic [127:0] K4 = 128'hEED5A3496E321A41C925F0389B236E36;
  localparam logic [127:0] D4 = 128'hD07A7228CF5E1ED034E14FA06FA08D49;
  localparam logic [127:0] K5 = 128'hAD711EC0ACD35F80C3E5EDD4E1336B6A;
  localparam logic [127:0] D5 = 128'hC0C148CF7C52DC9A10CCAB979FF03920;

  initial begin
    int lat;
    int cv_cnt;
    logic [127:0] c_before;
    n_rst        = 1'b0;
    key_in       = '0;
    key_load     = 1'b0;
    word_in      = '0;
    word_valid   = 1'b0;
    cipher_ready = 1'b0;
    repeat (3) tick();
    check("rst_cipher_out", cipher_out, 128'h0);
    check("rst_word_ready", word_ready, 1'b1);
    n_rst = 1'b1;
    tick();
    check("post_rst_busy", busy, 1'b0);

    // Nominal block with latency measurement and literal ciphertext.
    send_block(K1, D1, 0, 1, 0);
    check("enc_en_first_cycle", encryptEnable, 1'b1);
    check("nominal_inputData", inputData, D1);
    check("nominal_key", key, K1);
    wait_cipher(0, lat);
    check("nominal_latency", lat, L);
    check("nominal_cipher", cipher_out, C1);
    check("inputData_kept", inputData, D1);

    // Gapped words plus 10 cycles of back-pressure.
    send_block(K2, D2, 1, 1, 0);
    wait_cipher(0, lat);
    c_before = cipher_out;
    send_block(K2, D2 ^ 128'h1, 2, 0, 0);
    wait_cipher(10, lat);
    check("bp_cipher_changed", cipher_out != c_before, 1'b1);

    // key_load during ENCRYPT is ignored.
    send_block(K1, D1, 0, 1, 0);
    repeat (3) tick();
    key_load = 1'b1;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) tick();
    key_load = 1'b0;
    check("key_held_in_encrypt", key, K1);
    wait_cipher(1, lat);
    check("encrypt_keyload_cipher", cipher_out, C1);

    // key_load coincident with the 4th word takes effect for that block.
    load_key(K1);
    send_block(K4, D4, 1, 0, 1);
    check("key_with_last_word", key, K4);
    wait_cipher(0, lat);
    check("key_with_last_cipher", cipher_out, cipher_fn(K4, D4));

    // Reset at ENCRYPT cycle 15.
    send_block(K1, D1, 0, 1, 0);
    repeat (14) tick();
    n_rst = 1'b0;
    #1;
    check("arst_encryptEnable", encryptEnable, 1'b0);
    check("arst_cipher_valid", cipher_valid, 1'b0);
    check("arst_key", key, 128'h0);
    check("arst_inputData", inputData, 128'h0);
    check("arst_cipher_out", cipher_out, 128'h0);
    repeat (3) tick();
    n_rst  = 1'b1;
    cv_cnt = 0;
    repeat (40) begin
      tick();
      if (cipher_valid) cv_cnt++;
    end
    check("no_valid_after_reset", cv_cnt, 0);
    send_block(K5, D5, 0, 1, 0);
    wait_cipher(2, lat);
    check("post_reset_latency", lat, L);
    check("post_reset_cipher", cipher_out, cipher_fn(K5, D5));

    // Randomized traffic checked by the model.
    repeat (3000) begin
      word_valid   = ($urandom_range(0, 3) != 0);
      word_in      = $urandom;
      key_load     = ($urandom_range(0, 15) == 0);
      key_in       = {$urandom, $urandom, $urandom, $urandom};
      cipher_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    word_valid   = 1'b0;
    key_load     = 1'b0;
    cipher_ready = 1'b1;
    repeat (2 * L) tick();
    cipher_ready = 1'b0;
    tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("enough_handshakes", n_hs > 40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/encryption_feeder.md
ENCRYPTION_FEEDER -- requirements
Module: encryption_feeder

Interface
REQ-001 Parameter: ENC_LATENCY, default 31, cycles from the encryptEnable rising edge to the cycle in which outputData is sampled (range 2..255).
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 n_rst  input  1  reset; asynchronous, active-low.
REQ-004 key_in  input  128  cipher key.
REQ-005 key_load  input  1  captures key_in into the key register.
REQ-006 word_in  input  32  plaintext word.
REQ-007 word_valid  input  1  word_in is valid.
REQ-008 word_ready  output  1  block accepts word_in this cycle.
REQ-009 encryptEnable  output  1  start/hold for the encryption block.
REQ-010 key  output  128  key register, driven to the encryption block.
REQ-011 inputData  output  128  assembled plaintext block, driven to the encryption block.
REQ-012 outputData  input  128  ciphertext returned by the encryption block.
REQ-013 cipher_out  output  128  captured ciphertext.
REQ-014 cipher_valid  output  1  cipher_out holds a result.
REQ-015 cipher_ready  input  1  consumer accepts cipher_out.
REQ-016 busy  output  1  high in ENCRYPT or OUTPUT.

Function
REQ-017 FSM states: COLLECT, ENCRYPT, OUTPUT.
- Reset state: COLLECT.
REQ-018 COLLECT: word_ready = 1.
- A word is accepted when word_valid && word_ready.
- Word n (0..3) is written to inputData[127-32n -: 32], so the first word lands in the MSBs.
- A 2-bit word counter increments on each accepted word.
REQ-019 Acceptance of the 4th word:
- Counter wraps to 0.
- Next state is ENCRYPT.
- encryptEnable rises in the first ENCRYPT cycle.
REQ-020 ENCRYPT:
- word_ready = 0.
- encryptEnable = 1 continuously.
- key and inputData are held stable.
- An 8-bit latency counter counts ENCRYPT cycles.
REQ-021 ENC_LATENCY-th ENCRYPT cycle:
- At that posedge, outputData is registered into cipher_out.
- Next state is OUTPUT.
- encryptEnable = 0 in OUTPUT.
REQ-022 OUTPUT: cipher_valid = 1; cipher_out is held stable until cipher_valid && cipher_ready.
REQ-023 Handshake completion in OUTPUT:
- Next state is COLLECT; cipher_valid drops the following cycle.
- inputData is not cleared.
REQ-024 Valid/ready ordering:
- cipher_valid does not depend combinationally on cipher_ready.
- word_ready does not depend combinationally on word_valid.
REQ-025 key_load handling:
- Honoured only in COLLECT and OUTPUT; ignored in ENCRYPT.
- key_load on the same cycle as the 4th word is honoured, so the new key is used for that block.
REQ-026 word_valid during ENCRYPT or OUTPUT has no effect, and the word is not consumed.
REQ-027 Minimum throughput: one block per 4 + ENC_LATENCY + 1 cycles when cipher_ready is held high.

Reset
REQ-028 While n_rst = 0, the following are asynchronously cleared:
- state to COLLECT;
- both counters to 0;
- key, inputData and cipher_out to 128'h0;
- encryptEnable and cipher_valid to 0.
REQ-029 Outputs after reset release: word_ready = 1 and busy = 0 from the first cycle.
REQ-030 Reset asserted mid-ENCRYPT:
- The in-flight block is discarded.
- No cipher_valid pulse is produced.
- encryptEnable drops immediately (asynchronously).

Structure
REQ-031 Shared package aes_pkg holds:
- the state enum feeder_state_t;
- AES_BLOCK_W = 128;
- AES_WORD_W = 32;
- WORDS_PER_BLOCK = 4;
- the ENC_LATENCY default.
REQ-032 Single module with no sub-modules.
REQ-033 The top-level integration instantiates encryption_feeder beside encryption_block, connecting the same-named ports.

Verification
REQ-034 Directed scenarios, checked with encryption_block as the DUT partner:
- Nominal: key_load with 5E74E7BA66B0C7CC1B7697B3F9F51527, then words 7D8AE0F7, CFA0A6CB, 09FB5D05, A8EC586D on consecutive cycles -> cipher_valid exactly 31 cycles after encryptEnable rises, cipher_out = deb0f81341f3503a7cd01e2bc7cdd556.
- Back-pressure: cipher_ready held low for 10 cycles -> cipher_out stable, word_ready = 0, then release -> COLLECT.
- Gapped words: word_valid toggled 1/0 with key 33DE20E331BA5A525AB7C2495A767B5A and block E6FEBF30133874EBCB49226CD36D0D4F -> cipher_out = 67928dd5470d4a11f0ea4ae7d49b2dd4.
- key_load in ENCRYPT with any value -> ignored, ciphertext unchanged; key_load coincident with the 4th word (key EED5A3496E321A41C925F0389B236E36, block D07A7228CF5E1ED034E14FA06FA08D49) -> 71D31B8BA309FF7ABF61A6938CFA4267.
- Reset at ENCRYPT cycle 15 -> all outputs zero, no cipher_valid, next block (key AD711EC0ACD35F80C3E5EDD4E1336B6A, data C0C148CF7C52DC9A10CCAB979FF03920) -> 0EA6416862183B71C5A2B66E320FDDEB.
